// File: rtl/ah_pl2ddr_pkg.sv
// Shared definitions for the PL<->DDR AXI movers: command codes, FSM encodings,
// fixed AXI read-address fields and the latched run configuration.
package ah_pl2ddr_pkg;

  localparam logic [31:0] CMD_RST   = 32'h0000_0001;
  localparam logic [31:0] CMD_STOP  = 32'h0000_0020;
  localparam logic [31:0] CMD_START = 32'h0000_0021;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_SPACE = 3'd1;
  localparam logic [2:0] ST_ADDR       = 3'd2;
  localparam logic [2:0] ST_DATA       = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic [31:0] low;
    logic [31:0] high;
  } run_cfg_t;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ah_ddr2pl_fifo.sv
// Synchronous first-word-fall-through FIFO; the occupancy count drives the
// reader's space check before each burst is requested.
module ah_ddr2pl_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    do_pop   = pop && !empty;
    // A full FIFO can still take a word in the same cycle its head leaves.
    do_push  = push && (!full || do_pop);
    overflow = push && !do_push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    dout  = empty ? '0 : mem_q[rd_ptr_q];
    count = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ah_ddr2pl.sv
// AXI4 read master streaming a wrapping DDR region into a PL valid/ready stream.
// Optional data checker against a 0..7 counter: define AH_DDR2PL_PATTERN_CHECK_EN.
module ah_ddr2pl
  import ah_pl2ddr_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        m_axi_in_aclk,
  input  logic        m_axi_in_areset,
  input  logic [31:0] cmd_in,
  input  logic        cmd_en,
  output logic [31:0] cmd_processed,
  input  logic [31:0] number_samples,
  input  logic [31:0] ddr_addr_low,
  input  logic [31:0] ddr_addr_high,
  output logic [31:0] m_axi_in_araddr,
  output logic [7:0]  m_axi_in_arlen,
  output logic [2:0]  m_axi_in_arsize,
  output logic [1:0]  m_axi_in_arburst,
  output logic [3:0]  m_axi_in_arid,
  output logic        m_axi_in_arvalid,
  input  logic        m_axi_in_arready,
  input  logic [31:0] m_axi_in_rdata,
  input  logic [1:0]  m_axi_in_rresp,
  input  logic        m_axi_in_rlast,
  input  logic        m_axi_in_rvalid,
  output logic        m_axi_in_rready,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy,
  output logic        intr_done,
  output logic        intr_error,
  output logic [31:0] samples_read
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits for ready, and araddr/arlen hold while arvalid is up.

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] BURST_LEN_W  = 32'(BURST_LEN);
  localparam logic [31:0] FIFO_DEPTH_W = 32'(FIFO_DEPTH);

  logic [2:0]  state_q, state_d;
  run_cfg_t    cfg_q, cfg_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] samples_q, samples_d;
  logic [31:0] cmd_proc_q, cmd_proc_d;
  logic        stop_q, stop_d;
  logic        err_q, err_d;
  logic        intr_err_q, intr_err_d;

  logic        cmd_rst, cmd_stop, cmd_start, clr, start_ok, busy_int, push;
  logic [CW-1:0] fifo_count;
  logic        fifo_empty, fifo_overflow;
  logic [31:0] words_to_high, words_to_4k, beats_calc, free_slots;
  logic [8:0]  beats_cur;
  logic [32:0] next_addr;

`ifdef AH_DDR2PL_PATTERN_CHECK_EN
  logic [2:0]  pat_q, pat_d;
  logic        pat_err_q, pat_err_d;
`endif

  always_comb begin
    cmd_rst   = cmd_en && (cmd_in == CMD_RST);
    cmd_stop  = cmd_en && (cmd_in == CMD_STOP);
    cmd_start = cmd_en && (cmd_in == CMD_START);
    clr       = m_axi_in_areset || cmd_rst;
    start_ok  = (ddr_addr_low[1:0] == 2'b00) && (ddr_addr_high >= ddr_addr_low) &&
                (number_samples != 32'd0);
    busy_int  = (state_q == ST_WAIT_SPACE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    push      = (state_q == ST_DATA) && m_axi_in_rvalid;
    // Burst size: capped by the remaining count, the top of the region and the 4KB page.
    words_to_high = ((cfg_q.high - addr_q) >> 2) + 32'd1;
    words_to_4k   = (32'd4096 - {20'd0, addr_q[11:0]}) >> 2;
    beats_calc    = min32(min32(BURST_LEN_W, remaining_q), min32(words_to_high, words_to_4k));
    beats_cur     = {1'b0, arlen_q} + 9'd1;
    next_addr     = {1'b0, addr_q} + {22'd0, beats_cur, 2'b00};
    free_slots    = FIFO_DEPTH_W - 32'(fifo_count);
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    addr_d      = addr_q;
    arlen_d     = arlen_q;
    remaining_d = remaining_q;
    samples_d   = samples_q;
    stop_d      = stop_q;
    err_d       = err_q;
    intr_err_d  = 1'b0;
    cmd_proc_d  = cmd_proc_q;
`ifdef AH_DDR2PL_PATTERN_CHECK_EN
    pat_d       = pat_q;
    pat_err_d   = pat_err_q;
`endif
    if (cmd_rst || cmd_stop || cmd_start) cmd_proc_d = cmd_in;
    if (cmd_stop && busy_int) stop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          cfg_d.low   = ddr_addr_low;
          cfg_d.high  = ddr_addr_high;
          remaining_d = number_samples;
          if (start_ok) begin
            addr_d    = ddr_addr_low;
            samples_d = '0;
            stop_d    = 1'b0;
            err_d     = 1'b0;
            state_d   = ST_WAIT_SPACE;
`ifdef AH_DDR2PL_PATTERN_CHECK_EN
            pat_d     = '0;
            pat_err_d = 1'b0;
`endif
          end else begin
            intr_err_d = 1'b1;
          end
        end
      end
      ST_WAIT_SPACE: begin
        if (stop_q || err_q || (remaining_q == 32'd0)) begin
          state_d = ST_DONE;
        end else if (free_slots >= beats_calc) begin
          arlen_d = 8'(beats_calc - 32'd1);
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi_in_arready) begin
          addr_d  = (next_addr > {1'b0, cfg_q.high}) ? cfg_q.low : next_addr[31:0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (m_axi_in_rvalid) begin
          samples_d = samples_q + 32'd1;
          if (remaining_q != 32'd0) remaining_d = remaining_q - 32'd1;
          // Only the first bad response of a run raises the interrupt.
          if (m_axi_in_rresp != AXI_RESP_OKAY) begin
            err_d = 1'b1;
            if (!err_q) intr_err_d = 1'b1;
          end
`ifdef AH_DDR2PL_PATTERN_CHECK_EN
          pat_d = pat_q + 3'd1;
          if ((m_axi_in_rdata != {29'd0, pat_q}) && !pat_err_q) begin
            pat_err_d  = 1'b1;
            intr_err_d = 1'b1;
          end
`endif
          if (m_axi_in_rlast) begin
            state_d = ((remaining_d == 32'd0) || err_d || stop_d) ? ST_DONE : ST_WAIT_SPACE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (fifo_overflow) intr_err_d = 1'b1;
  end

  always_ff @(posedge m_axi_in_aclk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      addr_q      <= '0;
      arlen_q     <= '0;
      remaining_q <= '0;
      samples_q   <= '0;
      stop_q      <= 1'b0;
      err_q       <= 1'b0;
      intr_err_q  <= 1'b0;
`ifdef AH_DDR2PL_PATTERN_CHECK_EN
      pat_q       <= '0;
      pat_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      addr_q      <= addr_d;
      arlen_q     <= arlen_d;
      remaining_q <= remaining_d;
      samples_q   <= samples_d;
      stop_q      <= stop_d;
      err_q       <= err_d;
      intr_err_q  <= intr_err_d;
`ifdef AH_DDR2PL_PATTERN_CHECK_EN
      pat_q       <= pat_d;
      pat_err_q   <= pat_err_d;
`endif
    end
    // A soft reset still records itself as the last accepted command.
    if (m_axi_in_areset) cmd_proc_q <= '0;
    else                 cmd_proc_q <= cmd_proc_d;
  end

  ah_ddr2pl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk      (m_axi_in_aclk),
    .rst      (clr),
    .push     (push),
    .din      (m_axi_in_rdata),
    .pop      (data_ready),
    .dout     (data_out),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_overflow)
  );

  always_comb begin
    cmd_processed    = cmd_proc_q;
    m_axi_in_araddr  = addr_q;
    m_axi_in_arlen   = arlen_q;
    m_axi_in_arsize  = AXI_SIZE_4B;
    m_axi_in_arburst = AXI_BURST_INCR;
    m_axi_in_arid    = 4'd0;
    m_axi_in_arvalid = (state_q == ST_ADDR);
    m_axi_in_rready  = (state_q == ST_DATA);
    data_valid       = !fifo_empty;
    busy             = busy_int;
    intr_done        = (state_q == ST_DONE);
    intr_error       = intr_err_q;
    samples_read     = samples_q;
  end

endmodule
